// File: rtl/regfile_dump.sv
// 32x32 register file (r0 hard-wired to zero) with two combinational read ports,
// write-through bypass, and a sequential dump engine that streams r0..r31 once.
module regfile_dump (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB,
    input  logic        dump_start,
    output logic        dump_busy,
    output logic        dump_valid,
    output logic [4:0]  dump_index,
    output logic [31:0] dump_data,
    output logic        dump_done
);

    typedef enum logic {IDLE, DUMP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [4:0]  index_q, index_d;
    logic [31:0] data_q, data_d;

    logic wr_en;
    assign wr_en = ctrl_writeEnable && (ctrl_writeReg != 5'd0);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[ctrl_writeReg] = data_writeReg;
        end
    end

    // Index 0 never reaches the bypass or the array, so both ports read it as zero.
    always_comb begin
        data_readRegA = '0;
        data_readRegB = '0;
        if (ctrl_readRegA != 5'd0) begin
            data_readRegA = (wr_en && ctrl_writeReg == ctrl_readRegA) ? data_writeReg
                                                                     : regs_q[ctrl_readRegA];
        end
        if (ctrl_readRegB != 5'd0) begin
            data_readRegB = (wr_en && ctrl_writeReg == ctrl_readRegB) ? data_writeReg
                                                                     : regs_q[ctrl_readRegB];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        index_d = index_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = DUMP;
                    idx_d   = 5'd0;
                    busy_d  = 1'b1;
                end
            end
            DUMP: begin
                // Array is sampled before this edge's write, so a same-edge write dumps the old value.
                valid_d = 1'b1;
                index_d = idx_q;
                data_d  = regs_q[idx_q];
                idx_d   = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    idx_d   = 5'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register array is reset along with the control state because reset must clear r1..r31.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            regs_q  <= regs_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            index_q <= index_d;
            data_q  <= data_d;
        end
    end

    assign dump_busy  = busy_q;
    assign dump_valid = valid_q;
    assign dump_done  = done_q;
    assign dump_index = index_q;
    assign dump_data  = data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table-driven read/write/bypass vectors
// plus directed sequences for full dump, write during dump, and reset mid-dump.
module tb_regfile_dump;

    logic        clock;
    logic        reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        dump_done;

    int passed;
    int total;

    regfile_dump dut (
        .clock            (clock),
        .reset            (reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .dump_start       (dump_start),
        .dump_busy        (dump_busy),
        .dump_valid       (dump_valid),
        .dump_index       (dump_index),
        .dump_data        (dump_data),
        .dump_done        (dump_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_dump_idle(input string name);
        check({name, "_busy"},  32'(dump_busy),  32'd0);
        check({name, "_valid"}, 32'(dump_valid), 32'd0);
        check({name, "_done"},  32'(dump_done),  32'd0);
        check({name, "_index"}, 32'(dump_index), 32'd0);
        check({name, "_data"},  dump_data,       32'd0);
    endtask

    initial begin
        logic [31:0] exp_data;
        passed = 0;
        total  = 0;

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678};
        vecs[6]  = '{1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd7,  32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 5'd31, 32'h80000001, 5'd30, 5'd31, 32'h0,        32'h80000001};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'h80000001, 32'h0};
        vecs[10] = '{1'b1, 5'd1,  32'h00000001, 5'd2,  5'd1,  32'h0,        32'h00000001};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd31, 32'h00000001, 32'h80000001};

        reset            = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd31;
        dump_start       = 1'b0;

        #12;
        check_dump_idle("reset");
        check("reset_rd_a", data_readRegA, 32'd0);
        check("reset_rd_b", data_readRegB, 32'd0);
        reset = 1'b1;
        tick();

        // Read/write/bypass table: reads checked before the edge, write commits at it.
        for (int v = 0; v < 12; v++) begin
            ctrl_writeEnable = vecs[v].we;
            ctrl_writeReg    = vecs[v].wreg;
            data_writeReg    = vecs[v].wdata;
            ctrl_readRegA    = vecs[v].ra;
            ctrl_readRegB    = vecs[v].rb;
            #1;
            check($sformatf("vec%0d_a", v), data_readRegA, vecs[v].exp_a);
            check($sformatf("vec%0d_b", v), data_readRegB, vecs[v].exp_b);
            tick();
        end
        ctrl_writeEnable = 1'b0;

        // Preload r[i] = i*0x10.
        for (int i = 0; i < 32; i++) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = 5'(i);
            data_writeReg    = 32'(i * 16);
            tick();
        end
        ctrl_writeEnable = 1'b0;

        // Full dump with an ignored mid-dump start.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("dump1_start_busy",  32'(dump_busy),  32'd1);
        check("dump1_start_valid", 32'(dump_valid), 32'd0);
        for (int i = 0; i < 32; i++) begin
            dump_start = (i == 5);
            tick();
            dump_start = 1'b0;
            exp_data = 32'(i * 16);
            check($sformatf("dump1_valid%0d", i), 32'(dump_valid), 32'd1);
            check($sformatf("dump1_index%0d", i), 32'(dump_index), 32'(i));
            check($sformatf("dump1_data%0d", i),  dump_data,       exp_data);
            check($sformatf("dump1_done%0d", i),  32'(dump_done),  32'(i == 31));
            check($sformatf("dump1_busy%0d", i),  32'(dump_busy),  32'(i != 31));
        end

        // Restart at the earliest accepted edge, then write r3 on the edge that emits it.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("dump2_gap_valid", 32'(dump_valid), 32'd0);
        check("dump2_gap_done",  32'(dump_done),  32'd0);
        check("dump2_gap_busy",  32'(dump_busy),  32'd1);
        for (int i = 0; i < 32; i++) begin
            if (i == 3) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = 5'd3;
                data_writeReg    = 32'h0000AAAA;
            end
            tick();
            ctrl_writeEnable = 1'b0;
            exp_data = 32'(i * 16);
            check($sformatf("dump2_index%0d", i), 32'(dump_index), 32'(i));
            check($sformatf("dump2_data%0d", i),  dump_data,       exp_data);
            check($sformatf("dump2_done%0d", i),  32'(dump_done),  32'(i == 31));
        end
        ctrl_readRegA = 5'd3;
        #1;
        check("r3_after_dump", data_readRegA, 32'h0000AAAA);
        tick();
        check("dump2_end_valid", 32'(dump_valid), 32'd0);

        // Reset during the entry for index 10.
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
        end
        check("pre_rst_index", 32'(dump_index), 32'd10);
        check("pre_rst_data",  dump_data,       32'h000000A0);
        #1;
        reset = 1'b0;
        #1;
        check_dump_idle("mid_rst");
        ctrl_readRegA = 5'd3;
        ctrl_readRegB = 5'd31;
        #1;
        check("mid_rst_rd_a", data_readRegA, 32'd0);
        check("mid_rst_rd_b", data_readRegB, 32'd0);
        // Edge under reset: write and start must both be ignored.
        dump_start       = 1'b1;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd4;
        data_writeReg    = 32'h55555555;
        tick();
        dump_start       = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_readRegA    = 5'd4;
        #1;
        check("rst_write_ignored", data_readRegA, 32'd0);
        check_dump_idle("rst_held");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_valid%0d", i), 32'(dump_valid), 32'd0);
            check($sformatf("post_rst_done%0d", i),  32'(dump_done),  32'd0);
        end
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("dump3_busy", 32'(dump_busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("dump3_valid%0d", i), 32'(dump_valid), 32'd1);
            check($sformatf("dump3_index%0d", i), 32'(dump_index), 32'(i));
            check($sformatf("dump3_data%0d", i),  dump_data,       32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
